// File: rtl/otter_tb_pkg.sv
// Shared definitions for the otter_mcu end-of-test signature dump logic.
//   sig_dump_state_t : controller state encoding
//   *_PTR / RESET_VEC: default tohost / signature-bound locations for compliance runs
package otter_tb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      READ,
      WAIT,
      SEND,
      DONE,
      ERR
   } sig_dump_state_t;

   localparam logic [31:0] TOHOST_PTR    = 32'h8000_0000;
   localparam logic [31:0] SIG_START_PTR = 32'h8000_0004;
   localparam logic [31:0] SIG_END_PTR   = 32'h8000_0008;
   localparam logic [31:0] RESET_VEC     = 32'h8000_1000;

endpackage

// File: rtl/tohost_snoop.sv
// tohost store detector and configuration capture.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   arm_i               : detection enabled (controller idle)
//   dmem_*_i            : snooped core store port
//   tohost_addr_i       : address that ends the test
//   sig_start_i/end_i   : signature bounds, captured together with the tohost value
//   trigger_o           : qualified non-zero store to tohost this cycle
//   tohost_val_o        : captured store data
//   sig_start_o/end_o   : captured signature bounds
module tohost_snoop #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              arm_i,
   input  logic              dmem_w_en_i,
   input  logic [ADDR_W-1:0] dmem_addr_i,
   input  logic [ADDR_W-1:0] dmem_w_data_i,
   input  logic [ADDR_W-1:0] tohost_addr_i,
   input  logic [ADDR_W-1:0] sig_start_i,
   input  logic [ADDR_W-1:0] sig_end_i,
   output logic              trigger_o,
   output logic [ADDR_W-1:0] tohost_val_o,
   output logic [ADDR_W-1:0] sig_start_o,
   output logic [ADDR_W-1:0] sig_end_o
);

   logic [ADDR_W-1:0] tohost_val_q, tohost_val_d;
   logic [ADDR_W-1:0] sig_start_q, sig_start_d;
   logic [ADDR_W-1:0] sig_end_q, sig_end_d;

   // A zero store to tohost is a normal write, not an end-of-test marker.
   assign trigger_o = arm_i && dmem_w_en_i && (dmem_addr_i == tohost_addr_i) &&
                      (dmem_w_data_i != '0);

   always_comb begin
      tohost_val_d = tohost_val_q;
      sig_start_d  = sig_start_q;
      sig_end_d    = sig_end_q;
      if (trigger_o) begin
         tohost_val_d = dmem_w_data_i;
         sig_start_d  = sig_start_i;
         sig_end_d    = sig_end_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tohost_val_q <= '0;
         sig_start_q  <= '0;
         sig_end_q    <= '0;
      end else begin
         tohost_val_q <= tohost_val_d;
         sig_start_q  <= sig_start_d;
         sig_end_q    <= sig_end_d;
      end
   end

   assign tohost_val_o = tohost_val_q;
   assign sig_start_o  = sig_start_q;
   assign sig_end_o    = sig_end_q;

endmodule

// File: rtl/sig_dump_ctrl.sv
// End-of-test controller: halts the core on a non-zero tohost store, then streams the
// signature region [sig_start, sig_end) word by word over a valid/ready port.
//   clk, rst                          : clock, synchronous active-high reset
//   tohost_addr, sig_start/end_addr   : configuration, sampled at trigger
//   dmem_w_en/addr/w_data             : snooped core store port
//   mem_r_en, mem_addr, mem_r_data    : dump read port, data returns one cycle after mem_r_en
//   sig_valid/ready/data/last         : signature word stream
//   core_halt, tohost_val, done, range_err : status, sticky until reset
module sig_dump_ctrl
   import otter_tb_pkg::*;
#(
   parameter int unsigned MEM_EXP = 28,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] tohost_addr,
   input  logic [ADDR_W-1:0] sig_start_addr,
   input  logic [ADDR_W-1:0] sig_end_addr,
   input  logic              dmem_w_en,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [ADDR_W-1:0] dmem_w_data,
   output logic              mem_r_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [ADDR_W-1:0] mem_r_data,
   output logic              sig_valid,
   input  logic              sig_ready,
   output logic [ADDR_W-1:0] sig_data,
   output logic              sig_last,
   output logic              core_halt,
   output logic [ADDR_W-1:0] tohost_val,
   output logic              done,
   output logic              range_err
);

   localparam int unsigned IDX_W = MEM_EXP - 2;
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   sig_dump_state_t   state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [ADDR_W-1:0] hold_q, hold_d;

   logic              trigger;
   logic [ADDR_W-1:0] sig_start_q, sig_end_q;
   logic [IDX_W-1:0]  start_idx, end_idx;
   logic              is_last;

   tohost_snoop #(
      .ADDR_W (ADDR_W)
   ) u_snoop (
      .clk_i         (clk),
      .rst_i         (rst),
      .arm_i         (state_q == IDLE),
      .dmem_w_en_i   (dmem_w_en),
      .dmem_addr_i   (dmem_addr),
      .dmem_w_data_i (dmem_w_data),
      .tohost_addr_i (tohost_addr),
      .sig_start_i   (sig_start_addr),
      .sig_end_i     (sig_end_addr),
      .trigger_o     (trigger),
      .tohost_val_o  (tohost_val),
      .sig_start_o   (sig_start_q),
      .sig_end_o     (sig_end_q)
   );

   // Word indices within the memory; bits above MEM_EXP alias the same words.
   assign start_idx = sig_start_q[MEM_EXP-1:2];
   assign end_idx   = sig_end_q[MEM_EXP-1:2];
   assign is_last   = (ptr_q == (end_idx - IDX_ONE));

   logic unused_cfg_bits;
   assign unused_cfg_bits = ^{sig_end_q[ADDR_W-1:MEM_EXP], sig_end_q[1:0], sig_start_q[1:0]};

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      mem_r_en  = 1'b0;
      mem_addr  = '0;
      sig_valid = 1'b0;
      sig_last  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (trigger) state_d = CHECK;
         end
         CHECK: begin
            // Empty or inverted range: report and never touch memory.
            if (end_idx <= start_idx) begin
               state_d = ERR;
            end else begin
               ptr_d   = start_idx;
               state_d = READ;
            end
         end
         READ: begin
            mem_r_en = 1'b1;
            mem_addr = {sig_start_q[ADDR_W-1:MEM_EXP], ptr_q, 2'b00};
            state_d  = WAIT;
         end
         WAIT: begin
            hold_d  = mem_r_data;
            state_d = SEND;
         end
         SEND: begin
            sig_valid = 1'b1;
            sig_last  = is_last;
            if (sig_ready) begin
               if (is_last) begin
                  state_d = DONE;
               end else begin
                  ptr_d   = ptr_q + IDX_ONE;
                  state_d = READ;
               end
            end
         end
         DONE, ERR: begin
            state_d = state_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   assign sig_data  = hold_q;
   assign core_halt = (state_q != IDLE);
   assign done      = (state_q == DONE) || (state_q == ERR);
   assign range_err = (state_q == ERR);

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Self-checking bench for sig_dump_ctrl: table of snooped stores plus directed dump sequences.
module tb_sig_dump_ctrl;
   import otter_tb_pkg::*;

   localparam logic [31:0] TH  = 32'h8000_2000;
   localparam logic [31:0] SS  = 32'h8000_3000;
   localparam logic [31:0] SE  = 32'h8000_3010;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] tohost_addr = TH;
   logic [31:0] sig_start_addr = SS;
   logic [31:0] sig_end_addr = SE;
   logic        dmem_w_en = 1'b0;
   logic [31:0] dmem_addr = '0;
   logic [31:0] dmem_w_data = '0;
   logic        mem_r_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_r_data = '0;
   logic        sig_valid;
   logic        sig_ready = 1'b0;
   logic [31:0] sig_data;
   logic        sig_last;
   logic        core_halt;
   logic [31:0] tohost_val;
   logic        done;
   logic        range_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sig_dump_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .tohost_addr    (tohost_addr),
      .sig_start_addr (sig_start_addr),
      .sig_end_addr   (sig_end_addr),
      .dmem_w_en      (dmem_w_en),
      .dmem_addr      (dmem_addr),
      .dmem_w_data    (dmem_w_data),
      .mem_r_en       (mem_r_en),
      .mem_addr       (mem_addr),
      .mem_r_data     (mem_r_data),
      .sig_valid      (sig_valid),
      .sig_ready      (sig_ready),
      .sig_data       (sig_data),
      .sig_last       (sig_last),
      .core_halt      (core_halt),
      .tohost_val     (tohost_val),
      .done           (done),
      .range_err      (range_err)
   );

   // Synchronous memory: signature words 0xA0+i starting at SS.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] off;
      off = a - SS;
      if (off < 32'd64 && off[1:0] == 2'b00) return 32'hA0 + (off >> 2);
      return 32'hDEAD_BEEF;
   endfunction

   always @(posedge clk) if (mem_r_en) mem_r_data <= mem_word(mem_addr);

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      dmem_w_en = 1'b0;
      sig_ready = 1'b0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_mem_r_en"}, mem_r_en, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_sig_valid"}, sig_valid, 0);
      check({tag, "_sig_data"}, sig_data, 0);
      check({tag, "_sig_last"}, sig_last, 0);
      check({tag, "_core_halt"}, core_halt, 0);
      check({tag, "_tohost_val"}, tohost_val, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_range_err"}, range_err, 0);
      check({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
   endtask

   // One-cycle store; returns in the cycle after the store's edge.
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      dmem_w_en   = 1'b1;
      dmem_addr   = a;
      dmem_w_data = d;
      tick;
      dmem_w_en   = 1'b0;
   endtask

   // Entered in the cycle after the trigger edge (cycle 1 = CHECK, first valid due in cycle 4).
   task automatic run_dump(input bit stall, input bit inject, input bit rst_mid);
      int beats = 0;
      int k = 0;
      int first = 0;
      int c = 1;
      logic [31:0] held = '0;
      bit prev_hs = 1'b0;
      bit injected = 1'b0;
      while (c < 200 && !done) begin
         dmem_w_en = 1'b0;
         if (prev_hs) check("valid_drops_after_hs", sig_valid, 0);
         prev_hs = 1'b0;
         if (sig_valid) begin
            if (first == 0) first = c;
            if (rst_mid && beats == 1) begin
               rst = 1'b1;
               tick;
               rst = 1'b0;
               sig_ready = 1'b0;
               check_idle("rst_mid");
               return;
            end
            if (inject && beats == 1 && !injected) begin
               dmem_w_en   = 1'b1;
               dmem_addr   = TH;
               dmem_w_data = 32'h3;
               injected    = 1'b1;
            end
            if (k == 0) held = sig_data;
            else check("stall_data_stable", sig_data, held);
            check("no_ren_in_send", mem_r_en, 0);
            sig_ready = stall ? (k == 2) : 1'b1;
            if (sig_ready) begin
               check("beat_data", sig_data, 32'hA0 + beats);
               check("beat_last", sig_last, (beats == 3));
               if (stall) check("beat_held_cycles", k + 1, 3);
               beats++;
               k = 0;
               prev_hs = 1'b1;
            end else begin
               k++;
            end
         end
         tick;
         c++;
      end
      dmem_w_en = 1'b0;
      sig_ready = 1'b0;
      check("beat_count", beats, 4);
      check("first_valid_cycle", first, 4);
      check("dump_done", done, 1);
      check("dump_halt", core_halt, 1);
      check("dump_range_err", range_err, 0);
      check("dump_tohost_val", tohost_val, 1);
   endtask

   typedef struct {
      string       name;
      logic        w_en;
      logic [31:0] addr;
      logic [31:0] data;
      logic        exp_halt;
      logic        exp_ren;
      logic [31:0] exp_tohost;
   } vec_t;

   initial begin
      vec_t vecs[4];
      bit   bad;

      vecs[0] = '{"zero_data",  1'b1, TH,          32'h0, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{"wrong_addr", 1'b1, TH + 32'h4,  32'h5, 1'b0, 1'b0, 32'h0};
      vecs[2] = '{"no_wen",     1'b0, TH,          32'h7, 1'b0, 1'b0, 32'h0};
      vecs[3] = '{"trigger",    1'b1, TH,          32'h1, 1'b1, 1'b1, 32'h1};

      do_reset;
      check_idle("reset");

      foreach (vecs[i]) begin
         do_reset;
         dmem_w_en   = vecs[i].w_en;
         dmem_addr   = vecs[i].addr;
         dmem_w_data = vecs[i].data;
         tick;
         dmem_w_en = 1'b0;
         check({vecs[i].name, "_halt"}, core_halt, vecs[i].exp_halt);
         check({vecs[i].name, "_tohost_val"}, tohost_val, vecs[i].exp_tohost);
         check({vecs[i].name, "_ren_c1"}, mem_r_en, 0);
         tick;
         check({vecs[i].name, "_ren_c2"}, mem_r_en, vecs[i].exp_ren);
         check({vecs[i].name, "_halt_c2"}, core_halt, vecs[i].exp_halt);
      end

      // Normal dump, always ready.
      do_reset;
      store(TH, 32'h1);
      run_dump(1'b0, 1'b0, 1'b0);

      // Backpressure: ready 0,0,1 on every beat.
      do_reset;
      store(TH, 32'h1);
      run_dump(1'b1, 1'b0, 1'b0);

      // Second tohost store while streaming is ignored.
      do_reset;
      store(TH, 32'h1);
      run_dump(1'b0, 1'b1, 1'b0);
      check("inject_tohost_kept", tohost_val, 1);

      // Empty signature range.
      do_reset;
      sig_start_addr = SE;
      sig_end_addr   = SE;
      store(TH, 32'h1);
      bad = (sig_valid !== 1'b0) || (mem_r_en !== 1'b0);
      check("bad_range_err_c1", range_err, 0);
      tick;
      check("bad_range_err", range_err, 1);
      check("bad_range_done", done, 1);
      check("bad_range_halt", core_halt, 1);
      for (int i = 0; i < 6; i++) begin
         if (sig_valid !== 1'b0 || mem_r_en !== 1'b0) bad = 1'b1;
         tick;
      end
      check("bad_range_no_activity", bad, 0);
      check("bad_range_sticky", range_err, 1);
      sig_start_addr = SS;
      sig_end_addr   = SE;

      // Reset during beat 2, then a fresh dump from the first word.
      do_reset;
      store(TH, 32'h1);
      run_dump(1'b0, 1'b0, 1'b1);
      store(TH, 32'h1);
      run_dump(1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sig_dump_ctrl.md
Name: sig_dump_ctrl

Overview:
- Synthesizable end-of-test controller on the data-memory side of otter_mcu.
- Snoops the core's dmem write port for a non-zero store to the tohost address, then halts the core.
- Walks the signature region `[sig_start, sig_end)` through a dedicated synchronous memory read port and streams each 32-bit word out on a valid/ready interface.
- Replaces simulator-only signature dumping so compliance runs work on FPGA or emulation.

Parameters:
- MEM_EXP, 28, log2 of memory size in bytes; word index = addr[MEM_EXP-1:2].
- ADDR_W, 32, address and data width of snooped and config buses.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tohost_addr  in  32  tohost word address; sampled only at trigger
- sig_start_addr  in  32  signature start byte address; sampled at trigger
- sig_end_addr  in  32  signature end byte address, exclusive; sampled at trigger
- dmem_w_en  in  1  snooped core store enable
- dmem_addr  in  32  snooped core store address
- dmem_w_data  in  32  snooped core store data
- mem_r_en  out  1  dump read enable; memory returns data one cycle later
- mem_addr  out  32  dump read address, word aligned
- mem_r_data  in  32  dump read data
- sig_valid  out  1  signature word valid
- sig_ready  in  1  consumer ready
- sig_data  out  32  signature word
- sig_last  out  1  final word, qualified by sig_valid
- core_halt  out  1  freeze core; sticky until reset
- tohost_val  out  32  captured tohost data
- done  out  1  dump complete or aborted; sticky
- range_err  out  1  signature range invalid; sticky

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. rst takes priority over every event in the same cycle.
- Trigger condition, evaluated in IDLE only: dmem_w_en && dmem_addr==tohost_addr && dmem_w_data!=0.
  - Non-matching addresses and zero data are ignored.
  - Triggers outside IDLE are ignored.
- On trigger (edge N):
  - latch tohost_val and the three config inputs;
  - core_halt=1 from cycle N+1.
- Index computation: start_idx = (sig_start>>2) & MASK and end_idx = (sig_end>>2) & MASK, where MASK = 2^(MEM_EXP-2)-1.
- State sequence: IDLE -> CHECK -> READ -> WAIT -> SEND -> (READ | DONE | ERR).
- CHECK (1 cycle):
  - If end_idx <= start_idx, go to ERR.
  - Otherwise set ptr = start_idx and go to READ.
- READ (1 cycle): mem_r_en=1 and mem_addr = {upper bits of sig_start, ptr, 2'b00}. The upper bits above MEM_EXP are taken from the latched sig_start.
- WAIT (1 cycle): register mem_r_data into the holding register.
- SEND:
  - sig_valid=1, sig_data = holding register, sig_last = (ptr == end_idx-1).
  - sig_data and sig_last hold stable while sig_valid && !sig_ready.
  - On handshake (valid && ready): if last, go to DONE; otherwise ptr++ and go to READ.
  - sig_valid drops in the cycle after the handshake.
- Timing:
  - Throughput is at most one word per 3 cycles.
  - Latency from the trigger edge to the first sig_valid is 4 cycles (CHECK, READ, WAIT, then SEND).
- Pointer width is MEM_EXP-2 bits; the range check guarantees ptr never wraps during a dump.
- DONE: done=1 and core_halt stays 1. The block remains in DONE until rst.
- ERR: range_err=1, done=1, no reads are issued, sig_valid stays 0, core_halt stays 1.
- mem_r_en is 0 in every state except READ.
- Reset mid-dump: the block returns to IDLE on the next edge, sig_valid drops, and the halt is released.

Decomposition:
- Shared package otter_tb_pkg holds:
  - the state enum `sig_dump_state_t` {IDLE, CHECK, READ, WAIT, SEND, DONE, ERR};
  - default constants TOHOST_PTR=0x80000000, SIG_START_PTR=0x80000004, SIG_END_PTR=0x80000008, RESET_VEC=0x80001000.
- Optional sub-module tohost_snoop: the trigger comparator plus the capture registers for tohost value and config. The FSM and pointer stay in the top module.

Test Plan:
- Normal dump: tohost=0x80002000, sig=[0x80003000,0x80003010), memory holds words 0xA0..0xA3, store of 0x1 to tohost, sig_ready=1 -> tohost_val=0x1; exactly 4 beats 0xA0,0xA1,0xA2,0xA3; sig_last only on 0xA3; done=1; first sig_valid 4 cycles after the trigger edge.
- Backpressure: same setup, sig_ready toggles 0,0,1 per beat -> each word held stable for 3 cycles; no word lost or duplicated; no mem_r_en while stalled.
- Ignored writes:
  - store of 0x0 to tohost_addr -> no trigger;
  - store of 0x5 to tohost_addr+4 -> no trigger;
  - in both cases core_halt=0 and mem_r_en=0.
- Bad range: sig_start=0x80003010, sig_end=0x80003010, then trigger -> range_err=1 and done=1 within 2 cycles; no sig_valid and no mem_r_en ever.
- Reset mid-dump: assert rst while in SEND on beat 2 of 4 -> next cycle all outputs 0 and state IDLE; a fresh trigger afterwards restarts the dump from word 0xA0.
- Trigger while dumping: a second tohost store of 0x3 during SEND -> tohost_val stays 0x1 and the stream is unaffected.
